sdrc_req_split: RTL and testbench

Splits one SDRAM command into page-aligned sub-requests. It sits between the read side of the Wishbone-bridge command FIFO and the SDRAM controller request port, both in the SDRAM clock domain. Each incoming command (address, length, direction) is cut so that no sub-request crosses a column (page) boundary. Sub-requests are issued one at a time with a request/ack handshake.

---
 rtl/sdrc_split_pkg.sv | 31 +++
 rtl/sdrc_chunk_calc.sv | 34 +++
 rtl/sdrc_req_split.sv | 131 +++++++++++++
 tb/tb_sdrc_req_split.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_split_pkg.sv
// Shared types and constants for the SDRAM request splitter.
// Optional per-chunk cap is enabled by defining SDRC_SPLIT_CAP_EN.
package sdrc_split_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [1:0] COLBITS_8  = 2'b00;
  localparam logic [1:0] COLBITS_9  = 2'b01;
  localparam logic [1:0] COLBITS_10 = 2'b10;
  localparam logic [1:0] COLBITS_11 = 2'b11;

  // Wide enough to hold a full 2048-word page size.
  localparam int PAGE_REM_W = 12;

  function automatic logic [PAGE_REM_W-1:0] page_size(input logic [1:0] colbits);
    logic [PAGE_REM_W-1:0] sz;
    sz = '0;
    unique case (colbits)
      COLBITS_8:  sz = 12'd256;
      COLBITS_9:  sz = 12'd512;
      COLBITS_10: sz = 12'd1024;
      COLBITS_11: sz = 12'd2048;
      default:    sz = 12'd256;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/sdrc_chunk_calc.sv
// Combinational chunk sizer: min(remaining length, words left in page[, cap]).
// Cap applies only when SDRC_SPLIT_CAP_EN is defined.
module sdrc_chunk_calc
  import sdrc_split_pkg::*;
#(
  parameter int BL        = 9,
  parameter int MAX_CHUNK = 8
) (
  input  logic [PAGE_REM_W-2:0] addr,
  input  logic [BL-1:0]         rem_len,
  input  logic [1:0]            cfg_colbits,
  output logic [BL-1:0]         chunk
);

  logic [PAGE_REM_W-1:0] psize;
  logic [PAGE_REM_W-1:0] page_off;
  logic [PAGE_REM_W-1:0] page_rem;
  logic [PAGE_REM_W-1:0] len_ext;
  logic [PAGE_REM_W-1:0] min_len;

  always_comb begin
    psize    = page_size(cfg_colbits);
    // Only the low 11 address bits can fall inside the largest page.
    page_off = {1'b0, addr} & (psize - 12'd1);
    page_rem = psize - page_off;
    len_ext  = PAGE_REM_W'(rem_len);
    min_len  = (len_ext < page_rem) ? len_ext : page_rem;
`ifdef SDRC_SPLIT_CAP_EN
    if (min_len > PAGE_REM_W'(MAX_CHUNK)) min_len = PAGE_REM_W'(MAX_CHUNK);
`endif
    chunk = min_len[BL-1:0];
  end

endmodule

// File: rtl/sdrc_req_split.sv
// Splits one SDRAM command into page-aligned sub-requests issued by req/ack.
// SDRC_SPLIT_CAP_EN additionally limits each sub-request to MAX_CHUNK words.
module sdrc_req_split
  import sdrc_split_pkg::*;
#(
  parameter int APP_AW    = 30,
  parameter int BL        = 9,
  parameter int MAX_CHUNK = 8
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [1:0]        cfg_colbits,
  input  logic              req,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [BL-1:0]     req_len,
  input  logic              req_wr_n,
  output logic              req_ack,
  output logic              split_req,
  output logic [APP_AW-1:0] split_addr,
  output logic [BL-1:0]     split_len,
  output logic              split_wr_n,
  output logic              split_last,
  input  logic              split_ack,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [BL-1:0]     rem_q, rem_d;
  logic [BL-1:0]     len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic              last_q, last_d;
  logic              sreq_q, sreq_d;
  logic              busy_q, busy_d;

  logic [APP_AW-1:0] next_addr;
  logic [BL-1:0]     next_rem;
  logic [APP_AW-1:0] calc_addr;
  logic [BL-1:0]     calc_len;
  logic [BL-1:0]     chunk;

  // One sizer serves both the first chunk (from the command) and follow-ons.
  assign next_addr = addr_q + APP_AW'(len_q);
  assign next_rem  = rem_q - len_q;
  assign calc_addr = (state_q == IDLE) ? req_addr : next_addr;
  assign calc_len  = (state_q == IDLE) ? req_len  : next_rem;

  sdrc_chunk_calc #(
    .BL        (BL),
    .MAX_CHUNK (MAX_CHUNK)
  ) u_chunk (
    .addr        (calc_addr[PAGE_REM_W-2:0]),
    .rem_len     (calc_len),
    .cfg_colbits (cfg_colbits),
    .chunk       (chunk)
  );

  assign req_ack = req && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    wr_n_d  = wr_n_q;
    last_d  = last_q;
    sreq_d  = sreq_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        // Zero-length commands are popped and dropped without issuing.
        if (req && (req_len != '0)) begin
          state_d = ISSUE;
          addr_d  = req_addr;
          rem_d   = req_len;
          len_d   = chunk;
          wr_n_d  = req_wr_n;
          last_d  = (chunk == req_len);
          sreq_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (split_ack) begin
          if (last_q) begin
            state_d = IDLE;
            sreq_d  = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            addr_d = next_addr;
            rem_d  = next_rem;
            len_d  = chunk;
            last_d = (chunk == next_rem);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      wr_n_q  <= 1'b0;
      last_q  <= 1'b0;
      sreq_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      wr_n_q  <= wr_n_d;
      last_q  <= last_d;
      sreq_q  <= sreq_d;
      busy_q  <= busy_d;
    end
  end

  assign split_req  = sreq_q;
  assign split_addr = addr_q;
  assign split_len  = len_q;
  assign split_wr_n = wr_n_q;
  assign split_last = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sdrc_req_split.sv
// Scoreboard bench for sdrc_req_split: directed commands push expected chunks,
// a negedge monitor checks every presented sub-request against the queue head.
module tb_sdrc_req_split;

  localparam int APP_AW = 30;
  localparam int BL     = 9;

  typedef struct packed {
    logic [APP_AW-1:0] addr;
    logic [BL-1:0]     len;
    logic              wr_n;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        cfg_colbits = 2'b00;
  logic              req = 1'b0;
  logic [APP_AW-1:0] req_addr = '0;
  logic [BL-1:0]     req_len = '0;
  logic              req_wr_n = 1'b0;
  logic              req_ack;
  logic              split_req;
  logic [APP_AW-1:0] split_addr;
  logic [BL-1:0]     split_len;
  logic              split_wr_n;
  logic              split_last;
  logic              split_ack = 1'b0;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int stall = 0;
  int ack_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sdrc_req_split dut (
    .sdram_clk    (clk),
    .sdram_resetn (rst_n),
    .cfg_colbits  (cfg_colbits),
    .req          (req),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wr_n     (req_wr_n),
    .req_ack      (req_ack),
    .split_req    (split_req),
    .split_addr   (split_addr),
    .split_len    (split_len),
    .split_wr_n   (split_wr_n),
    .split_last   (split_last),
    .split_ack    (split_ack),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [APP_AW-1:0] a, input logic [BL-1:0] l,
                              input logic w, input logic last);
    exp_t e;
    e.addr = a; e.len = l; e.wr_n = w; e.last = last;
    return e;
  endfunction

  // Ack generator: holds split_ack low for `stall` cycles on every chunk.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !split_req) begin
        ack_cnt   = 0;
        split_ack = (stall == 0) && rst_n;
      end else begin
        if (split_ack) ack_cnt = 0;
        if (ack_cnt >= stall) split_ack = 1'b1;
        else begin
          split_ack = 1'b0;
          ack_cnt++;
        end
      end
    end
  end

  // Monitor: every cycle a sub-request is shown it must equal the queue head.
  always @(negedge clk) begin
    if (rst_n && split_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_subreq", {34'd0, split_addr}, 64'hDEAD);
      end else begin
        chk("sub_addr", 64'(split_addr), 64'(exp_q[0].addr));
        chk("sub_len",  64'(split_len),  64'(exp_q[0].len));
        chk("sub_wr_n", 64'(split_wr_n), 64'(exp_q[0].wr_n));
        chk("sub_last", 64'(split_last), 64'(exp_q[0].last));
        if (split_ack) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic send(input logic [APP_AW-1:0] a, input logic [BL-1:0] l,
                      input logic w, input logic [1:0] cb);
    @(posedge clk); #1;
    cfg_colbits = cb; req = 1'b1; req_addr = a; req_len = l; req_wr_n = w;
    @(negedge clk);
    chk("req_ack_hi", 64'(req_ack), 64'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("req_ack_lo", 64'(req_ack), 64'd0);
    chk("first_latency_req", 64'(split_req), 64'(l != 0));
    chk("first_latency_busy", 64'(busy), 64'(l != 0));
  endtask

  initial begin
    #2;
    chk("rst_split_req", 64'(split_req), 64'd0);
    chk("rst_split_addr", 64'(split_addr), 64'd0);
    chk("rst_split_len", 64'(split_len), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    #20 rst_n = 1'b1;

    // Single word, ack tied high; busy lasts exactly one cycle.
    stall = 0;
    exp_q.push_back(mk(30'h10, 9'd1, 1'b0, 1'b1));
    send(30'h10, 9'd1, 1'b0, 2'b00);
    @(negedge clk);
    chk("single_busy_one_cycle", 64'(busy), 64'd0);
    wait_idle("single");

    // Page crossing, back-to-back chunks.
    exp_q.push_back(mk(30'h0FE, 9'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(30'h100, 9'd3, 1'b1, 1'b1));
    send(30'h0FE, 9'd5, 1'b1, 2'b00);
    wait_idle("page_cross");

    // Same with 10-cycle stalls; monitor checks stability every stalled cycle.
    stall = 10;
    exp_q.push_back(mk(30'h0FE, 9'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(30'h100, 9'd3, 1'b1, 1'b1));
    send(30'h0FE, 9'd5, 1'b1, 2'b00);
    wait_idle("backpressure");

    // Zero length: popped, nothing issued.
    stall = 0;
    send(30'h55, 9'd0, 1'b0, 2'b00);
    @(negedge clk);
    chk("zero_len_req", 64'(split_req), 64'd0);
    chk("zero_len_busy", 64'(busy), 64'd0);

    // Address wrap at the top of the space.
    exp_q.push_back(mk(30'h3FFFFFFF, 9'd1, 1'b0, 1'b0));
    exp_q.push_back(mk(30'h00000000, 9'd1, 1'b0, 1'b1));
    send(30'h3FFFFFFF, 9'd2, 1'b0, 2'b11);
    wait_idle("wrap");

    // Long command inside one 512-word page.
`ifdef SDRC_SPLIT_CAP_EN
    exp_q.push_back(mk(30'd0,  9'd8, 1'b1, 1'b0));
    exp_q.push_back(mk(30'd8,  9'd8, 1'b1, 1'b0));
    exp_q.push_back(mk(30'd16, 9'd4, 1'b1, 1'b1));
`else
    exp_q.push_back(mk(30'd0, 9'd20, 1'b1, 1'b1));
`endif
    send(30'd0, 9'd20, 1'b1, 2'b01);
    wait_idle("long");

    // Reset in the middle of the second chunk.
    stall = 3;
    exp_q.push_back(mk(30'h1F8, 9'd8, 1'b0, 1'b0));
`ifdef SDRC_SPLIT_CAP_EN
    exp_q.push_back(mk(30'h200, 9'd8, 1'b0, 1'b0));
`else
    exp_q.push_back(mk(30'h200, 9'd12, 1'b0, 1'b1));
`endif
    send(30'h1F8, 9'd20, 1'b0, 2'b01);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (split_req && split_addr == 30'h200) begin
          seen = 1'b1;
          break;
        end
      end
      chk("reset_reached_chunk2", 64'(seen), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_split_req", 64'(split_req), 64'd0);
    chk("abort_split_addr", 64'(split_addr), 64'd0);
    chk("abort_split_len", 64'(split_len), 64'd0);
    chk("abort_split_wr_n", 64'(split_wr_n), 64'd0);
    chk("abort_split_last", 64'(split_last), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fresh command after reset.
    stall = 0;
    exp_q.push_back(mk(30'h1FC, 9'd4, 1'b1, 1'b0));
    exp_q.push_back(mk(30'h200, 9'd2, 1'b1, 1'b1));
    send(30'h1FC, 9'd6, 1'b1, 2'b01);
    wait_idle("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
